// File: rtl/tone_sequencer_if.sv
// Control, pattern, tone inputs and status outputs of the tone sequencer.
// The master drives tones and control, the slave (sequencer) drives status.
interface tone_sequencer_if #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned SEQ_LEN = 8,
  parameter int unsigned IDX_W   = 3
);
  logic [N_CH-1:0]          in_wires;
  logic [SEQ_LEN*SEL_W-1:0] pattern;
  logic                     start;
  logic                     stop;
  logic                     loop_en;
  logic                     speaker;
  logic [IDX_W-1:0]         step;
  logic                     busy;
  logic                     done;

  modport master (
    output in_wires, pattern, start, stop, loop_en,
    input  speaker, step, busy, done
  );

  modport slave (
    input  in_wires, pattern, start, stop, loop_en,
    output speaker, step, busy, done
  );
endinterface

// File: rtl/tone_sequencer.sv
// Steps through a latched sequence of tone selectors, one step per beat,
// and routes the chosen tone wire (or silence) to the speaker.
module tone_sequencer #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned SEL_W       = 3,
  parameter int unsigned SEQ_LEN     = 8,
  parameter int unsigned IDX_W       = 3,
  parameter int unsigned BEAT_CYCLES = 67108864,
  parameter int unsigned GAP_CYCLES  = 0
) (
  input  logic              clk,
  input  logic              reset,
  tone_sequencer_if.slave   bus
);

  localparam int unsigned CNT_W     = 32;
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GATE_END  = CNT_W'(BEAT_CYCLES - GAP_CYCLES);
  localparam logic [IDX_W-1:0] STEP_LAST = IDX_W'(SEQ_LEN - 1);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t                   state;
  logic [CNT_W-1:0]         beat_cnt;
  logic [SEQ_LEN*SEL_W-1:0] pat_q;
  logic [IDX_W-1:0]         step_q;
  logic                     speaker_q;
  logic                     busy_q;
  logic                     done_q;

  logic [SEL_W-1:0]         sel_c;
  logic                     tone_c;
  logic                     gate_c;

  // Selector of the current step from the latched pattern
  always_comb begin
    sel_c = '0;
    for (int k = 0; k < SEQ_LEN; k++) begin
      if (step_q == IDX_W'(k)) sel_c = pat_q[k*SEL_W +: SEL_W];
    end
  end

  // Tone routing: selector 0 and selectors above N_CH are rests
  always_comb begin
    tone_c = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel_c == SEL_W'(i + 1)) tone_c = bus.in_wires[i];
    end
  end

  assign gate_c = (beat_cnt < GATE_END);

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      pat_q     <= '0;
      step_q    <= '0;
      speaker_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          speaker_q <= 1'b0;
          if (bus.start && !bus.stop) begin
            state    <= PLAY;
            busy_q   <= 1'b1;
            step_q   <= '0;
            beat_cnt <= '0;
            pat_q    <= bus.pattern;
          end
        end
        PLAY: begin
          if (bus.stop) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            speaker_q <= 1'b0;
            step_q    <= '0;
            beat_cnt  <= '0;
          end else begin
            speaker_q <= tone_c & gate_c;
            if (beat_cnt == BEAT_LAST) begin
              beat_cnt <= '0;
              if (step_q != STEP_LAST) begin
                step_q <= step_q + IDX_W'(1);
              end else if (bus.loop_en) begin
                step_q <= '0;
              end else begin
                state  <= IDLE;
                busy_q <= 1'b0;
                step_q <= '0;
                done_q <= 1'b1;
              end
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.speaker = speaker_q;
  assign bus.step    = step_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with a 4-step, 4-clock-beat, 1-clock-gap setup.
module tb_tone_sequencer;

  localparam int unsigned N_CH        = 2;
  localparam int unsigned SEL_W       = 2;
  localparam int unsigned SEQ_LEN     = 4;
  localparam int unsigned IDX_W       = 2;
  localparam int unsigned BEAT_CYCLES = 4;
  localparam int unsigned GAP_CYCLES  = 1;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  tone_sequencer_if #(.N_CH(N_CH), .SEL_W(SEL_W), .SEQ_LEN(SEQ_LEN), .IDX_W(IDX_W)) sig ();

  tone_sequencer #(
    .N_CH(N_CH), .SEL_W(SEL_W), .SEQ_LEN(SEQ_LEN), .IDX_W(IDX_W),
    .BEAT_CYCLES(BEAT_CYCLES), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sig.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"},    32'(sig.busy),    32'd0);
    check({tag, ".step"},    32'(sig.step),    32'd0);
    check({tag, ".speaker"}, 32'(sig.speaker), 32'd0);
    check({tag, ".done"},    32'(sig.done),    32'd0);
  endtask

  // Start edge: one cycle of start, leaves the block at step 0 beat 0
  task automatic do_start();
    sig.start = 1'b1;
    tick();
    sig.start = 1'b0;
  endtask

  task automatic do_stop();
    sig.stop = 1'b1;
    tick();
    sig.stop = 1'b0;
  endtask

  logic [15:0] t1_spk;
  logic        w_prev;
  logic [31:0] exp_spk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass       = 0;
    n_total      = 0;
    reset        = 1'b1;
    sig.in_wires = '0;
    sig.pattern  = '0;
    sig.start    = 1'b0;
    sig.stop     = 1'b0;
    sig.loop_en  = 1'b0;
    tick();
    tick();
    check_idle("reset");
    reset = 1'b0;
    tick();
    check_idle("post_reset");

    // 1. One-shot: steps {1,2,0,3}, both tones high
    sig.pattern  = 8'b11_00_10_01;
    sig.in_wires = 2'b11;
    t1_spk       = 16'b0000_0000_0111_0111; // bit e-1 = speaker after play edge e
    do_start();
    check("t1.busy0", 32'(sig.busy), 32'd1);
    check("t1.step0", 32'(sig.step), 32'd0);
    for (int e = 1; e <= 16; e++) begin
      tick();
      check($sformatf("t1.spk[%0d]", e), 32'(sig.speaker), 32'(t1_spk[e-1]));
      if (e < 16) begin
        check($sformatf("t1.step[%0d]", e), 32'(sig.step), 32'(e / 4));
        check($sformatf("t1.busy[%0d]", e), 32'(sig.busy), 32'd1);
        check($sformatf("t1.done[%0d]", e), 32'(sig.done), 32'd0);
      end else begin
        check("t1.done_pulse", 32'(sig.done), 32'd1);
        check("t1.busy_end",   32'(sig.busy), 32'd0);
        check("t1.step_end",   32'(sig.step), 32'd0);
      end
    end
    tick();
    check_idle("t1.after");

    // 2. Channel routing: steps {1,2,1,2}, tone 0 toggling, tone 1 low
    sig.pattern  = 8'b10_01_10_01;
    sig.in_wires = 2'b00;
    do_start();
    for (int e = 1; e <= 16; e++) begin
      w_prev       = 1'(e % 2);
      sig.in_wires = {1'b0, w_prev};
      tick();
      exp_spk = ((((e - 1) / 4) % 2 == 0) && ((e - 1) % 4 < 3)) ? 32'(w_prev) : 32'd0;
      check($sformatf("t2.spk[%0d]", e), 32'(sig.speaker), exp_spk);
    end
    check("t2.done", 32'(sig.done), 32'd1);
    tick();

    // 3. Loop mode, then drop loop_en in the middle of step 3
    sig.pattern  = 8'b11_00_10_01;
    sig.in_wires = 2'b11;
    sig.loop_en  = 1'b1;
    do_start();
    for (int e = 1; e <= 48; e++) begin
      tick();
      if (e == 45) sig.loop_en = 1'b0;
      if (e < 48) begin
        check($sformatf("t3.step[%0d]", e), 32'(sig.step), 32'((e / 4) % 4));
        check($sformatf("t3.busy[%0d]", e), 32'(sig.busy), 32'd1);
        check($sformatf("t3.done[%0d]", e), 32'(sig.done), 32'd0);
      end else begin
        check("t3.done_pulse", 32'(sig.done), 32'd1);
        check("t3.busy_end",   32'(sig.busy), 32'd0);
      end
    end
    tick();
    check_idle("t3.after");

    // 4a. Stop during step 1 beat 2, where the speaker would otherwise be high
    do_start();
    for (int e = 1; e <= 6; e++) tick();
    check("t4.step_pre", 32'(sig.step), 32'd1);
    do_stop();
    check_idle("t4.stop");
    // 4b. start and stop together in IDLE
    sig.start = 1'b1;
    sig.stop  = 1'b1;
    tick();
    check("t4.both_busy", 32'(sig.busy), 32'd0);
    sig.start = 1'b0;
    sig.stop  = 1'b0;
    tick();
    check("t4.both_busy2", 32'(sig.busy), 32'd0);
    // 4c. start held during PLAY must not restart
    do_start();
    for (int e = 1; e <= 5; e++) tick();
    sig.start = 1'b1;
    tick();
    check("t4.hold_step6", 32'(sig.step), 32'd1);
    tick();
    check("t4.hold_step7", 32'(sig.step), 32'd1);
    tick();
    check("t4.hold_step8", 32'(sig.step), 32'd2);
    sig.start = 1'b0;
    do_stop();
    check_idle("t4.end");

    // 5. Pattern latched at start; later changes wait for the next start
    sig.pattern = 8'b11_00_10_01;
    do_start();
    sig.pattern = 8'b00_00_00_00;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("t5.spk[%0d]", e), 32'(sig.speaker), 32'(t1_spk[e-1]));
    end
    do_stop();
    do_start();
    for (int e = 1; e <= 3; e++) begin
      tick();
      check($sformatf("t5.new_spk[%0d]", e), 32'(sig.speaker), 32'd0);
    end
    do_stop();

    // 6. Asynchronous reset between edges during step 2 with speaker high
    sig.pattern = 8'b01_01_01_01;
    do_start();
    for (int e = 1; e <= 9; e++) tick();
    check("t6.step_pre", 32'(sig.step),    32'd2);
    check("t6.spk_pre",  32'(sig.speaker), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_idle("t6.async");
    tick();
    reset = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      check_idle($sformatf("t6.idle[%0d]", e));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
